// File: rtl/weigh_filter_pkg.sv
// Shared constants and types for the weigh_filter scale path.
// The ADC rail codes are used only when WEIGH_RAIL_REJECT_EN is defined.
package weigh_pkg;

  localparam int AVG_LOG2_DEF = 3;
  localparam int FRAC_BITS    = 12;
  localparam int MUL_CYCLES   = 16;

  localparam logic [23:0] RAIL_POS = 24'h7FFFFF;
  localparam logic [23:0] RAIL_NEG = 24'h800000;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    AVG,
    MUL,
    OUT
  } state_t;

endpackage

// File: rtl/weigh_filter_seq_mult_u16.sv
// 16-cycle unsigned shift-add multiplier: a (A_W bits) x b (16 bits).
// 'start' loads the operands. 'done' pulses once the product is final.
module seq_mult_u16
  import weigh_pkg::*;
#(
  parameter int A_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [A_W-1:0]   a,
  input  logic [15:0]      b,
  output logic [A_W+15:0]  product,
  output logic             done
);

  localparam logic [4:0] LAST = 5'(MUL_CYCLES - 1);

  logic [A_W+15:0] mcand;
  logic [15:0]     mplier;
  logic [4:0]      cnt;
  logic            running;

  // One multiplier bit per cycle, LSB first; the multiplicand shifts left to follow it
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= (A_W+16)'(a);
        mplier  <= b;
        product <= '0;
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) begin
          product <= product + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 5'd1;
        if (cnt == LAST) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/weigh_filter.sv
// weigh_filter: moving average, tare, offset subtraction and Q4.12 gain for the scale.
// Optional build macro WEIGH_RAIL_REJECT_EN discards ADC saturation codes in IDLE.
module weigh_filter
  import weigh_pkg::*;
#(
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int STABLE_TOL = 200,
  parameter int STABLE_CNT = 4,
  parameter int OUT_W      = 20
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic [23:0]       raw_value,
  input  logic              raw_valid,
  input  logic              tare_req,
  input  logic [15:0]       scale_k,
  output logic [OUT_W-1:0]  weight,
  output logic              weight_valid,
  output logic              stable,
  output logic              tare_done,
  output logic              busy
);

  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int SUM_W  = 24 + AVG_LOG2;
  localparam int CNT_W  = $clog2(STABLE_CNT + 1);
  localparam int PROD_W = 41;
  localparam logic [AVG_LOG2:0]  FULL    = (AVG_LOG2+1)'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [PROD_W-1:0]  W_MAX   = {{(PROD_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  state_t state, next_state;

  logic signed [23:0]      buffer [DEPTH];
  logic signed [23:0]      sample, pend_value, cand, avg, offset, prev_avg, eff_offset;
  logic signed [SUM_W-1:0] sum;
  logic signed [24:0]      net, diff;
  logic [24:0]             net_abs, diff_abs;
  logic [AVG_LOG2-1:0]     wr_ptr;
  logic [AVG_LOG2:0]       fill_cnt;
  logic [CNT_W-1:0]        stab_cnt;
  logic [PROD_W-1:0]       product, scaled;
  logic                    pend_valid, tare_pend, have_prev, net_neg;
  logic                    take, rail, full, in_tol, mul_start, mul_done;

  assign take = raw_valid | pend_valid;
  assign cand = raw_valid ? raw_value : pend_value;
`ifdef WEIGH_RAIL_REJECT_EN
  assign rail = (cand == RAIL_POS) || (cand == RAIL_NEG);
`else
  assign rail = 1'b0;
`endif

  assign full       = (fill_cnt == FULL);
  assign avg        = 24'(sum >>> AVG_LOG2);
  assign eff_offset = tare_pend ? avg : offset;
  assign net        = 25'(avg) - 25'(eff_offset);
  assign net_abs    = net[24] ? 25'(-net) : 25'(net);
  assign diff       = 25'(avg) - 25'(prev_avg);
  assign diff_abs   = diff[24] ? 25'(-diff) : 25'(diff);
  assign in_tol     = diff_abs <= 25'(STABLE_TOL);
  assign scaled     = product >> FRAC_BITS;

  assign stable = (stab_cnt == CNT_MAX);
  assign busy   = (state != IDLE);

  seq_mult_u16 #(.A_W(25)) u_mult (
    .clk     (clk_50),
    .rst     (rst),
    .start   (mul_start),
    .a       (net_abs),
    .b       (scale_k),
    .product (product),
    .done    (mul_done)
  );

  // State register
  always_ff @(posedge clk_50) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; the multiplier is kicked off on the AVG -> MUL transition
  always_comb begin
    next_state = state;
    mul_start  = 1'b0;
    case (state)
      IDLE: if (take && !rail) next_state = ACC;
      ACC:  next_state = AVG;
      AVG: begin
        if (full) begin
          next_state = MUL;
          mul_start  = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      MUL:  if (mul_done) next_state = OUT;
      OUT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Samples arriving while busy park in a one-deep slot (newest wins); tare requests collapse into one flag
  always_ff @(posedge clk_50) begin
    if (rst) begin
      pend_value <= '0;
      pend_valid <= 1'b0;
      tare_pend  <= 1'b0;
    end else begin
      if (state != IDLE) begin
        if (raw_valid) begin
          pend_value <= raw_value;
          pend_valid <= 1'b1;
        end
      end else if (take) begin
        pend_valid <= 1'b0;
      end
      if (tare_req)                      tare_pend <= 1'b1;
      else if ((state == AVG) && full)   tare_pend <= 1'b0;
    end
  end

  // Averaging window, tare offset, stability tracking and output publication
  always_ff @(posedge clk_50) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
      sample       <= '0;
      sum          <= '0;
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      offset       <= '0;
      prev_avg     <= '0;
      have_prev    <= 1'b0;
      stab_cnt     <= '0;
      net_neg      <= 1'b0;
      weight       <= '0;
      weight_valid <= 1'b0;
      tare_done    <= 1'b0;
    end else begin
      weight_valid <= 1'b0;
      tare_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (rail) stab_cnt <= '0;
            else      sample   <= cand;
          end
        end
        ACC: begin
          buffer[wr_ptr] <= sample;
          sum            <= sum + SUM_W'(sample) - SUM_W'(buffer[wr_ptr]);
          wr_ptr         <= wr_ptr + 1'b1;
          if (!full) fill_cnt <= fill_cnt + 1'b1;
        end
        AVG: begin
          if (full) begin
            if (tare_pend) begin
              offset    <= avg;
              tare_done <= 1'b1;
            end
            net_neg  <= net[24];
            prev_avg <= avg;
            if (!have_prev) begin
              have_prev <= 1'b1;
            end else if (in_tol) begin
              if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + 1'b1;
            end else begin
              stab_cnt <= '0;
            end
          end
        end
        OUT: begin
          weight_valid <= 1'b1;
          if (net_neg)             weight <= '0;
          else if (scaled > W_MAX) weight <= '1;
          else                     weight <= scaled[OUT_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
